// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined execute core: 74181 opcode
// encodings for the operations the sequencer issues, mode encodings
// and the packed flag register layout.
package cpu_pkg;

    // 74181 S3..S0 encodings (active-high data)
    localparam logic [3:0] OP_ADD    = 4'b1001;  // arithmetic, cin = 0
    localparam logic [3:0] OP_SUB    = 4'b0110;  // arithmetic, cin = 1
    localparam logic [3:0] OP_AND    = 4'b1011;  // logic
    localparam logic [3:0] OP_OR     = 4'b1110;  // logic
    localparam logic [3:0] OP_PASS_B = 4'b1010;  // logic, used as load

    localparam logic MODE_MATH  = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    // Persistent flag register; nbo/ngo are active-low group P/G
    typedef struct packed {
        logic c;
        logic z;
        logic nbo;
        logic ngo;
    } flags_t;

endpackage

// File: rtl/alu181_slice.sv
// One 4-bit 74181-style ALU slice (active-high data). Carry-in is
// active-high (1 adds one); Cn+4 ripples into the next slice and the
// active-low group propagate/generate feed the cross-slice flags.
module alu181_slice
    import cpu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cin,
    output logic [3:0] f,
    output logic       cout,
    output logic       p_n,
    output logic       g_n
);

    // Per-bit terms: the arithmetic result is t + u + cin, and u is a
    // subset of t so t is the bit propagate and u the bit generate.
    logic [3:0] t;
    logic [3:0] u;
    logic [4:0] c;

    // Select the two per-bit operand terms from S3..S0
    always_comb begin
        t = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        u = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    end

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign c[gi+1] = u[gi] | (t[gi] & c[gi]);
            // Logic mode ignores the carry entirely
            assign f[gi]   = (m == MODE_LOGIC) ? ~(t[gi] ^ u[gi])
                                               : (t[gi] ^ u[gi] ^ c[gi]);
        end
    endgenerate

    assign cout = c[4];
    assign p_n  = ~(&t);
    assign g_n  = ~(u[3] | (t[3] & u[2]) | (t[3] & t[2] & u[1])
                  | (t[3] & t[2] & t[1] & u[0]));

endmodule

// File: rtl/cpu_pipe_core.sv
// Two-stage pipelined execute core: inline write-through register file,
// 74181-style ALU built from 4-bit slices, B-source mux, valid/ready
// handshake, in-order writeback and a persistent flag register whose
// carry can feed the next instruction without a stall.
// Build option CPU_PIPE_FWD_EN: when defined, operands are bypassed from
// the ALU output and the WB register and the core never stalls; when
// undefined, in_ready drops while a register hazard exists.
module cpu_pipe_core
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_comm,
    input  logic                  in_mode,
    input  logic                  in_cin,
    input  logic                  in_use_flag_c,
    input  logic                  in_b_sel,
    input  logic                  in_we,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic [DATA_WIDTH-1:0] in_imm,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic                  flag_c,
    output logic                  flag_z,
    output logic                  flag_nbo,
    output logic                  flag_ngo,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int NUM_SLICES = DATA_WIDTH / 4;

    logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];

    // EX stage
    logic                  ex_valid_reg;
    logic [DATA_WIDTH-1:0] ex_a_reg;
    logic [DATA_WIDTH-1:0] ex_b_reg;
    logic [3:0]            ex_comm_reg;
    logic                  ex_mode_reg;
    logic                  ex_cin_reg;
    logic                  ex_use_flag_c_reg;
    logic                  ex_we_reg;
    logic [ADDR_WIDTH-1:0] ex_rd_reg;

    // WB stage
    logic                  wb_valid_reg;
    logic [DATA_WIDTH-1:0] wb_result_reg;
    logic [ADDR_WIDTH-1:0] wb_rd_reg;
    logic                  wb_we_reg;

    flags_t flags_reg;
    flags_t flags_next;

    logic                  accept;
    logic                  wb_write;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  carry_in;
    logic [NUM_SLICES:0]   carry;
    logic [NUM_SLICES-1:0] slice_p_n;
    logic [NUM_SLICES-1:0] slice_g_n;
    logic [NUM_SLICES:0]   grp_p;
    logic [NUM_SLICES:0]   grp_g;

    assign wb_write = wb_valid_reg & wb_we_reg;
    assign accept   = in_valid & in_ready;

`ifdef CPU_PIPE_FWD_EN
    assign in_ready = ~reset;
`else
    logic rs1_haz;
    logic rs2_haz;

    // Stall while a source register is still owned by an in-flight writer
    always_comb begin
        rs1_haz = (ex_valid_reg && ex_we_reg && (ex_rd_reg == in_rs1))
               || (wb_write && (wb_rd_reg == in_rs1));
        rs2_haz = !in_b_sel
               && ((ex_valid_reg && ex_we_reg && (ex_rd_reg == in_rs2))
                   || (wb_write && (wb_rd_reg == in_rs2)));
    end

    assign in_ready = ~reset & ~(rs1_haz | rs2_haz);
`endif

    // Operand fetch: write-through from WB, then (if enabled) EX bypass wins
    always_comb begin
        rs1_data = regs_reg[in_rs1];
        rs2_data = regs_reg[in_rs2];
        if (wb_write && (wb_rd_reg == in_rs1)) rs1_data = wb_result_reg;
        if (wb_write && (wb_rd_reg == in_rs2)) rs2_data = wb_result_reg;
`ifdef CPU_PIPE_FWD_EN
        if (ex_valid_reg && ex_we_reg && (ex_rd_reg == in_rs1)) rs1_data = alu_result;
        if (ex_valid_reg && ex_we_reg && (ex_rd_reg == in_rs2)) rs2_data = alu_result;
`endif
    end

    assign op_b = in_b_sel ? in_imm : rs2_data;

    // Carry chaining reads the flag as it stands while the instruction is in EX
    assign carry_in = ex_use_flag_c_reg ? flags_reg.c : ex_cin_reg;
    assign carry[0] = carry_in;
    assign grp_p[0] = 1'b1;
    assign grp_g[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
            alu181_slice u_slice (
                .a    (ex_a_reg[4*gi +: 4]),
                .b    (ex_b_reg[4*gi +: 4]),
                .s    (ex_comm_reg),
                .m    (ex_mode_reg),
                .cin  (carry[gi]),
                .f    (alu_result[4*gi +: 4]),
                .cout (carry[gi+1]),
                .p_n  (slice_p_n[gi]),
                .g_n  (slice_g_n[gi])
            );
            // Lookahead-style combination of slice P/G, LSB slice first
            assign grp_p[gi+1] = grp_p[gi] & ~slice_p_n[gi];
            assign grp_g[gi+1] = ~slice_g_n[gi] | (~slice_p_n[gi] & grp_g[gi]);
        end
    endgenerate

    // Flags produced by the instruction currently in EX
    always_comb begin
        flags_next.c   = (ex_mode_reg == MODE_MATH) ? carry[NUM_SLICES] : 1'b0;
        flags_next.z   = (alu_result == '0);
        flags_next.nbo = ~grp_p[NUM_SLICES];
        flags_next.ngo = ~grp_g[NUM_SLICES];
    end

    // Pipeline registers and flag register; reset discards in-flight work
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_reg      <= 1'b0;
            ex_a_reg          <= '0;
            ex_b_reg          <= '0;
            ex_comm_reg       <= '0;
            ex_mode_reg       <= 1'b0;
            ex_cin_reg        <= 1'b0;
            ex_use_flag_c_reg <= 1'b0;
            ex_we_reg         <= 1'b0;
            ex_rd_reg         <= '0;
            wb_valid_reg      <= 1'b0;
            wb_result_reg     <= '0;
            wb_rd_reg         <= '0;
            wb_we_reg         <= 1'b0;
            flags_reg         <= '0;
        end else begin
            ex_valid_reg <= accept;
            if (accept) begin
                ex_a_reg          <= rs1_data;
                ex_b_reg          <= op_b;
                ex_comm_reg       <= in_comm;
                ex_mode_reg       <= in_mode;
                ex_cin_reg        <= in_cin;
                ex_use_flag_c_reg <= in_use_flag_c;
                ex_we_reg         <= in_we;
                ex_rd_reg         <= in_rd;
            end
            wb_valid_reg <= ex_valid_reg;
            if (ex_valid_reg) begin
                wb_result_reg <= alu_result;
                wb_rd_reg     <= ex_rd_reg;
                wb_we_reg     <= ex_we_reg;
                flags_reg     <= flags_next;
            end
        end
    end

    // Register file write port, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wb_write) begin
            regs_reg[wb_rd_reg] <= wb_result_reg;
        end
    end

    assign dbg_data   = regs_reg[dbg_addr];
    assign out_valid  = wb_valid_reg;
    assign out_result = wb_result_reg;
    assign out_rd     = wb_rd_reg;
    assign flag_c     = flags_reg.c;
    assign flag_z     = flags_reg.z;
    assign flag_nbo   = flags_reg.nbo;
    assign flag_ngo   = flags_reg.ngo;

endmodule

// File: tb/tb_cpu_pipe_core.sv
// Scoreboard bench for cpu_pipe_core: each accepted instruction is run
// through a small sequential model and its expected result/flags queued;
// the output monitor pops and compares on every out_valid pulse.
module tb_cpu_pipe_core;
    import cpu_pkg::*;

    localparam int DW = 16;
    localparam int NR = 8;
    localparam int AW = 3;

`ifdef CPU_PIPE_FWD_EN
    localparam int EXP_DEP_STALLS = 0;
`else
    localparam int EXP_DEP_STALLS = 2;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_comm;
    logic          in_mode;
    logic          in_cin;
    logic          in_use_flag_c;
    logic          in_b_sel;
    logic          in_we;
    logic [AW-1:0] in_rd;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic [DW-1:0] in_imm;
    logic          out_valid;
    logic [DW-1:0] out_result;
    logic [AW-1:0] out_rd;
    logic          flag_c;
    logic          flag_z;
    logic          flag_nbo;
    logic          flag_ngo;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    cpu_pipe_core #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_comm       (in_comm),
        .in_mode       (in_mode),
        .in_cin        (in_cin),
        .in_use_flag_c (in_use_flag_c),
        .in_b_sel      (in_b_sel),
        .in_we         (in_we),
        .in_rd         (in_rd),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_imm        (in_imm),
        .out_valid     (out_valid),
        .out_result    (out_result),
        .out_rd        (out_rd),
        .flag_c        (flag_c),
        .flag_z        (flag_z),
        .flag_nbo      (flag_nbo),
        .flag_ngo      (flag_ngo),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] result;
        logic [AW-1:0] rd;
        logic          c;
        logic          z;
        logic          nbo;
        logic          ngo;
        logic          chk_pg;
        int            cyc;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    logic [DW-1:0] model_regs [NR];
    logic          model_c;
    int            n_checks  = 0;
    int            n_errors  = 0;
    int            cyc       = 0;
    int            out_count = 0;
    int            stalls;
    int            saved_count;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one instruction, wait (bounded) for in_ready, model it, queue it
    task automatic issue(input logic [3:0] comm, input logic mode, input logic cin,
                         input logic use_fc, input logic b_sel, input logic we,
                         input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2, input logic [DW-1:0] imm,
                         output int n_stall);
        logic [DW-1:0] a, b, nb, res;
        logic [DW:0]   sum, gsum;
        logic          ci;
        exp_t          e;
        in_comm = comm; in_mode = mode; in_cin = cin; in_use_flag_c = use_fc;
        in_b_sel = b_sel; in_we = we; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_imm = imm; in_valid = 1'b1;
        #1;
        n_stall = 0;
        while (!in_ready && n_stall < 8) begin
            @(negedge clk);
            #1;
            n_stall++;
        end
        if (!in_ready) begin
            check("issue_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        a  = model_regs[rs1];
        b  = b_sel ? imm : model_regs[rs2];
        ci = use_fc ? model_c : cin;
        e.c = 1'b0; e.nbo = 1'b0; e.ngo = 1'b0; e.chk_pg = 1'b0;
        case ({mode, comm})
            {MODE_MATH, OP_ADD}: begin
                sum  = {1'b0, a} + {1'b0, b} + (DW+1)'(ci);
                gsum = {1'b0, a} + {1'b0, b};
                res = sum[DW-1:0]; e.c = sum[DW];
                e.nbo = ~&(a | b); e.ngo = ~gsum[DW]; e.chk_pg = 1'b1;
            end
            {MODE_MATH, OP_SUB}: begin
                nb   = ~b;
                sum  = {1'b0, a} + {1'b0, nb} + (DW+1)'(ci);
                gsum = {1'b0, a} + {1'b0, nb};
                res = sum[DW-1:0]; e.c = sum[DW];
                e.nbo = ~&(a | nb); e.ngo = ~gsum[DW]; e.chk_pg = 1'b1;
            end
            {MODE_LOGIC, OP_AND}:    res = a & b;
            {MODE_LOGIC, OP_OR}:     res = a | b;
            {MODE_LOGIC, OP_PASS_B}: res = b;
            default:                 res = '0;
        endcase
        e.result = res;
        e.z      = (res == '0);
        e.rd     = rd;
        e.cyc    = cyc;
        model_c  = e.c;
        if (we) model_regs[rd] = res;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Read every register through the debug port and compare with the model
    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++) begin
            @(negedge clk);
            dbg_addr = AW'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(model_regs[i]));
        end
        @(negedge clk);
    endtask

    // Output monitor: one line per completed transaction
    always @(negedge clk) begin
        if (out_valid) begin
            out_count++;
            if (sb_q.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                $display("t=%0t out rd=%0d result=0x%04h c=%0b z=%0b nbo=%0b ngo=%0b",
                         $time, out_rd, out_result, flag_c, flag_z, flag_nbo, flag_ngo);
                check("result", 32'(out_result), 32'(mon_e.result));
                check("out_rd", 32'(out_rd), 32'(mon_e.rd));
                check("flag_c", 32'(flag_c), 32'(mon_e.c));
                check("flag_z", 32'(flag_z), 32'(mon_e.z));
                if (mon_e.chk_pg) begin
                    check("flag_nbo", 32'(flag_nbo), 32'(mon_e.nbo));
                    check("flag_ngo", 32'(flag_ngo), 32'(mon_e.ngo));
                end
                check("latency", 32'(cyc - mon_e.cyc), 32'd2);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_comm = '0; in_mode = 1'b0; in_cin = 1'b0;
        in_use_flag_c = 1'b0; in_b_sel = 1'b0; in_we = 1'b0; in_rd = '0;
        in_rs1 = '0; in_rs2 = '0; in_imm = '0; dbg_addr = '0;
        for (int i = 0; i < NR; i++) model_regs[i] = '0;
        model_c = 1'b0;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", 32'(in_ready), 32'd0);
        check("out_valid_reset", 32'(out_valid), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(in_ready), 32'd1);
        check("rst_flag_c", 32'(flag_c), 32'd0);
        check("rst_flag_z", 32'(flag_z), 32'd0);
        check("rst_flag_nbo", 32'(flag_nbo), 32'd0);
        check("rst_flag_ngo", 32'(flag_ngo), 32'd0);
        check_regs("rst");

        // Load and add, then dependent AND
        issue(OP_PASS_B, MODE_LOGIC, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 3'd0, 3'd0, 16'h1234, stalls);
        issue(OP_PASS_B, MODE_LOGIC, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 3'd0, 3'd0, 16'h5678, stalls);
        issue(OP_ADD,    MODE_MATH,  1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 3'd2, 3'd3, 16'h0000, stalls);
        issue(OP_AND,    MODE_LOGIC, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 3'd4, 3'd0, 16'h00FF, stalls);
        check("dep_stalls", 32'(stalls), 32'(EXP_DEP_STALLS));
        repeat (4) @(negedge clk);
        check_regs("add");

        // Carry chain across two back-to-back adds
        issue(OP_PASS_B, MODE_LOGIC, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 3'd0, 3'd0, 16'hFFFF, stalls);
        issue(OP_ADD,    MODE_MATH,  1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 3'd1, 3'd0, 16'h0001, stalls);
        issue(OP_ADD,    MODE_MATH,  1'b0, 1'b1, 1'b1, 1'b1, 3'd6, 3'd0, 3'd0, 16'h0000, stalls);
        check("chain_stalls", 32'(stalls), 32'd0);

        // OR into r7, then SUB with no writeback
        issue(OP_OR,     MODE_LOGIC, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 3'd2, 3'd3, 16'h0000, stalls);
        issue(OP_SUB,    MODE_MATH,  1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 3'd2, 3'd3, 16'h0000, stalls);
        repeat (4) @(negedge clk);
        check_regs("sub");

        // Reset one cycle after accepting a load: it must vanish
        saved_count = out_count;
        in_comm = OP_PASS_B; in_mode = MODE_LOGIC; in_cin = 1'b0; in_use_flag_c = 1'b0;
        in_b_sel = 1'b1; in_we = 1'b1; in_rd = 3'd7; in_rs1 = '0; in_rs2 = '0;
        in_imm = 16'hBEEF; in_valid = 1'b1;
        #1;
        check("midrst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_no_out", 32'(out_count - saved_count), 32'd0);
        check("midrst_flag_c", 32'(flag_c), 32'd0);
        check("midrst_flag_z", 32'(flag_z), 32'd0);
        check("midrst_flag_nbo", 32'(flag_nbo), 32'd0);
        check("midrst_flag_ngo", 32'(flag_ngo), 32'd0);
        for (int i = 0; i < NR; i++) model_regs[i] = '0;
        model_c = 1'b0;
        check_regs("midrst");

        // Core works normally after the reset
        issue(OP_ADD, MODE_MATH, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 3'd0, 3'd0, 16'h0042, stalls);
        repeat (4) @(negedge clk);
        check_regs("post");

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
